// File: rtl/uart_tx_serializer_if.sv
// ----------------------------------------------------------------------------
// uart_tx_serializer_if
//   Byte write handshake between a producer (e.g. the sync-FIFO test
//   controller) and the UART transmitter.
//   uart_tx_en_in      producer -> tx : one-cycle write strobe
//   uart_tx_data_in    producer -> tx : byte, valid while uart_tx_en_in=1
//   uart_tx_ready_out  tx -> producer : 1 = transmitter input buffer empty
//   Modports: master (producer side), slave (transmitter side).
// ----------------------------------------------------------------------------
interface uart_tx_serializer_if #(
    parameter int DATA_BITS = 8
) ();
    logic                 uart_tx_en_in;
    logic [DATA_BITS-1:0] uart_tx_data_in;
    logic                 uart_tx_ready_out;

    modport master (
        output uart_tx_en_in,
        output uart_tx_data_in,
        input  uart_tx_ready_out
    );

    modport slave (
        input  uart_tx_en_in,
        input  uart_tx_data_in,
        output uart_tx_ready_out
    );
endinterface

// File: rtl/uart_tx_serializer.sv
// ----------------------------------------------------------------------------
// uart_tx_serializer
//   UART transmitter with a 2-entry input buffer. Each accepted byte is sent
//   as start bit, DATA_BITS payload bits (LSB first), optional parity bit and
//   STOP_BITS stop bits, each bit lasting CLKS_PER_BIT clocks. Buffered bytes
//   follow the previous frame with no idle gap.
// Ports:
//   clk_in              system clock, rising edge
//   n_rst               asynchronous active-low reset
//   tx_if               write handshake (slave side): en / data / ready
//   uart_tx_busy_out    1 = frame in progress or buffer non-empty
//   uart_tx_overrun_out sticky: a write arrived while the buffer was full
//   uart_tx_serial_out  TX pin, registered, idles high
// ----------------------------------------------------------------------------
module uart_tx_serializer #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 217,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                   clk_in,
    input  logic                   n_rst,
    uart_tx_serializer_if.slave    tx_if,
    output logic                   uart_tx_busy_out,
    output logic                   uart_tx_overrun_out,
    output logic                   uart_tx_serial_out
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = $clog2(DATA_BITS + 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // Parity of the payload: even -> XOR of bits, odd -> its complement.
    function automatic logic parity_bit(input logic [DATA_BITS-1:0] d);
        logic p;
        if (PARITY == 2) begin
            p = ^d;
        end else begin
            p = ~^d;
        end
        return p;
    endfunction

    state_t               state_r;
    state_t               state_next_s;
    logic [CNT_W-1:0]     baud_cnt_r;
    logic [IDX_W-1:0]     bit_idx_r;
    logic [DATA_BITS-1:0] shift_r;
    logic [DATA_BITS-1:0] data_r;
    logic [DATA_BITS-1:0] fifo_mem_r [2];
    logic                 wr_ptr_r;
    logic                 rd_ptr_r;
    logic [1:0]           count_r;
    logic [1:0]           count_next_s;
    logic                 push_s;
    logic                 drop_s;
    logic                 pop_s;
    logic                 pin_s;
    logic                 bit_tick_s;
    logic                 last_data_s;
    logic                 last_stop_s;
    logic [DATA_BITS-1:0] head_s;
    logic                 serial_r;
    logic                 ready_r;
    logic                 busy_r;
    logic                 overrun_r;

    // A write is accepted whenever a slot is free; ready is only advisory.
    assign push_s      = tx_if.uart_tx_en_in && (count_r != 2'd2);
    assign drop_s      = tx_if.uart_tx_en_in && (count_r == 2'd2);
    assign head_s      = fifo_mem_r[rd_ptr_r];
    assign bit_tick_s  = (baud_cnt_r == CNT_W'(CLKS_PER_BIT - 1));
    assign last_data_s = (bit_idx_r == IDX_W'(DATA_BITS - 1));
    assign last_stop_s = (bit_idx_r == IDX_W'(STOP_BITS - 1));

    assign tx_if.uart_tx_ready_out = ready_r;
    assign uart_tx_busy_out        = busy_r;
    assign uart_tx_overrun_out     = overrun_r;
    assign uart_tx_serial_out      = serial_r;

    // Buffer occupancy after this cycle's push/pop.
    always_comb begin
        count_next_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + 2'd1;
            2'b01:   count_next_s = count_r - 2'd1;
            default: count_next_s = count_r;
        endcase
    end

    // Frame sequencer: next state, buffer pop and pin level for this state.
    always_comb begin
        state_next_s = state_r;
        pop_s        = 1'b0;
        pin_s        = 1'b1;
        case (state_r)
            ST_IDLE: begin
                pin_s = 1'b1;
                if (count_r != 2'd0) begin
                    pop_s        = 1'b1;
                    state_next_s = ST_START;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_START: begin
                pin_s = 1'b0;
                if (bit_tick_s) begin
                    state_next_s = ST_DATA;
                end else begin
                    state_next_s = ST_START;
                end
            end
            ST_DATA: begin
                pin_s = shift_r[0];
                if (bit_tick_s && last_data_s) begin
                    state_next_s = (PARITY != 0) ? ST_PARITY : ST_STOP;
                end else begin
                    state_next_s = ST_DATA;
                end
            end
            ST_PARITY: begin
                pin_s = parity_bit(data_r);
                if (bit_tick_s) begin
                    state_next_s = ST_STOP;
                end else begin
                    state_next_s = ST_PARITY;
                end
            end
            ST_STOP: begin
                pin_s = 1'b1;
                if (bit_tick_s && last_stop_s) begin
                    // Chain straight into the next frame when a byte waits.
                    if (count_r != 2'd0) begin
                        pop_s        = 1'b1;
                        state_next_s = ST_START;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end else begin
                    state_next_s = ST_STOP;
                end
            end
            default: begin
                pin_s        = 1'b1;
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk_in or negedge n_rst) begin
        if (!n_rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Baud counter and per-state bit index (data bits, then stop bits).
    always_ff @(posedge clk_in or negedge n_rst) begin
        if (!n_rst) begin
            baud_cnt_r <= '0;
            bit_idx_r  <= '0;
        end else begin
            if ((state_r == ST_IDLE) || bit_tick_s) begin
                baud_cnt_r <= '0;
            end else begin
                baud_cnt_r <= baud_cnt_r + CNT_W'(1);
            end
            if (bit_tick_s && (state_next_s != state_r)) begin
                bit_idx_r <= '0;
            end else if (bit_tick_s) begin
                bit_idx_r <= bit_idx_r + IDX_W'(1);
            end else begin
                bit_idx_r <= bit_idx_r;
            end
        end
    end

    // Shift register loaded on pop, shifted at the end of each data bit.
    always_ff @(posedge clk_in or negedge n_rst) begin
        if (!n_rst) begin
            shift_r <= '0;
            data_r  <= '0;
        end else if (pop_s) begin
            shift_r <= head_s;
            data_r  <= head_s;
        end else if ((state_r == ST_DATA) && bit_tick_s) begin
            shift_r <= shift_r >> 1;
        end else begin
            shift_r <= shift_r;
        end
    end

    // Two-entry input FIFO storage and pointers.
    always_ff @(posedge clk_in or negedge n_rst) begin
        if (!n_rst) begin
            fifo_mem_r[0] <= '0;
            fifo_mem_r[1] <= '0;
            wr_ptr_r      <= 1'b0;
            rd_ptr_r      <= 1'b0;
            count_r       <= 2'd0;
        end else begin
            if (push_s) begin
                fifo_mem_r[wr_ptr_r] <= tx_if.uart_tx_data_in;
                wr_ptr_r             <= ~wr_ptr_r;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            count_r <= count_next_s;
        end
    end

    // Registered outputs; ready/busy use next-state values so they track the
    // current register contents without any path from en to the pins.
    always_ff @(posedge clk_in or negedge n_rst) begin
        if (!n_rst) begin
            serial_r  <= 1'b1;
            ready_r   <= 1'b1;
            busy_r    <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            serial_r  <= pin_s;
            ready_r   <= (count_next_s == 2'd0);
            busy_r    <= (state_next_s != ST_IDLE) || (count_next_s != 2'd0);
            overrun_r <= overrun_r || drop_s;
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_serializer
//   Four transmitter instances (8N1, 8E2, 8O1 at 4 clk/bit, 8N1 at 217 clk/bit)
//   checked against a frame-bit reference and a mid-bit sampling UART receiver.
// ----------------------------------------------------------------------------
module tb_uart_tx_serializer;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    logic [3:0] pin;
    logic [3:0] busy;
    logic [3:0] ovr;
    wire  [3:0] rdy;

    int          rx_cnt  [4];
    int          rx_rd   [4];
    int          rx_ferr [4];
    logic [7:0]  rx_data [4][64];
    int          rx_start[4][64];

    uart_tx_serializer_if #(.DATA_BITS(8)) if0 ();
    uart_tx_serializer_if #(.DATA_BITS(8)) if1 ();
    uart_tx_serializer_if #(.DATA_BITS(8)) if2 ();
    uart_tx_serializer_if #(.DATA_BITS(8)) if3 ();

    assign rdy = {if3.uart_tx_ready_out, if2.uart_tx_ready_out,
                  if1.uart_tx_ready_out, if0.uart_tx_ready_out};

    uart_tx_serializer #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(1)) dut0 (
        .clk_in(clk), .n_rst(n_rst), .tx_if(if0),
        .uart_tx_busy_out(busy[0]), .uart_tx_overrun_out(ovr[0]), .uart_tx_serial_out(pin[0]));
    uart_tx_serializer #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY(2), .STOP_BITS(2)) dut1 (
        .clk_in(clk), .n_rst(n_rst), .tx_if(if1),
        .uart_tx_busy_out(busy[1]), .uart_tx_overrun_out(ovr[1]), .uart_tx_serial_out(pin[1]));
    uart_tx_serializer #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(1)) dut2 (
        .clk_in(clk), .n_rst(n_rst), .tx_if(if2),
        .uart_tx_busy_out(busy[2]), .uart_tx_overrun_out(ovr[2]), .uart_tx_serial_out(pin[2]));
    uart_tx_serializer #(.DATA_BITS(8), .CLKS_PER_BIT(217), .PARITY(0), .STOP_BITS(1)) dut3 (
        .clk_in(clk), .n_rst(n_rst), .tx_if(if3),
        .uart_tx_busy_out(busy[3]), .uart_tx_overrun_out(ovr[3]), .uart_tx_serial_out(pin[3]));

    always #5 clk = ~clk;

    // Free-running cycle count used to timestamp received start bits.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int idx, input logic en, input logic [7:0] d);
        case (idx)
            0: begin if0.uart_tx_en_in = en; if0.uart_tx_data_in = d; end
            1: begin if1.uart_tx_en_in = en; if1.uart_tx_data_in = d; end
            2: begin if2.uart_tx_en_in = en; if2.uart_tx_data_in = d; end
            default: begin if3.uart_tx_en_in = en; if3.uart_tx_data_in = d; end
        endcase
    endtask

    // Expected line level of each bit of a frame, index 0 = start bit.
    function automatic logic [15:0] frame_bits(input logic [7:0] d, input int par);
        logic [15:0] f;
        int ones;
        f = 16'hFFFF;
        ones = 0;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            f[1 + i] = d[i];
            ones += int'(d[i]);
        end
        if (par == 2) f[9] = ((ones % 2) == 1);
        else if (par == 1) f[9] = ((ones % 2) == 0);
        return f;
    endfunction

    // Receiver: detects the start edge, samples every bit in its middle.
    task automatic rx_mon(input int idx, input int cpb, input int par, input int stops);
        logic [7:0] b;
        logic [15:0] f;
        int bad;
        int start_c;
        forever begin
            @(negedge clk);
            if (pin[idx] == 1'b0) begin
                start_c = cyc;
                bad = 0;
                b = 8'h00;
                repeat (cpb / 2) @(negedge clk);
                if (pin[idx] != 1'b0) bad = 1;
                for (int i = 0; i < 8; i++) begin
                    repeat (cpb) @(negedge clk);
                    b[i] = pin[idx];
                end
                if (par != 0) begin
                    f = frame_bits(b, par);
                    repeat (cpb) @(negedge clk);
                    if (pin[idx] != f[9]) bad = 1;
                end
                for (int s = 0; s < stops; s++) begin
                    repeat (cpb) @(negedge clk);
                    if (pin[idx] != 1'b1) bad = 1;
                end
                if (rx_cnt[idx] < 64) begin
                    rx_data[idx][rx_cnt[idx]]  = b;
                    rx_start[idx][rx_cnt[idx]] = start_c;
                    rx_cnt[idx]++;
                end
                rx_ferr[idx] += bad;
            end
        end
    endtask

    task automatic expect_rx(input int idx, input logic [7:0] d, input string tag);
        int t;
        t = 0;
        while ((rx_cnt[idx] <= rx_rd[idx]) && (t < 5000)) begin
            @(negedge clk);
            t++;
        end
        if (rx_cnt[idx] <= rx_rd[idx]) begin
            check({tag, "_timeout"}, 64'(rx_cnt[idx] - rx_rd[idx]), 64'd1);
        end else begin
            check(tag, 64'(rx_data[idx][rx_rd[idx]]), 64'(d));
            rx_rd[idx]++;
        end
    endtask

    // Single write into an idle instance (4 clk/bit); checks latency, ready,
    // the full pin waveform and how long busy stays high.
    task automatic send_frame(input int idx, input logic [7:0] d, input int par,
                              input int stops, input string tag);
        int nb, n, lat, bcnt;
        logic r_after_write, r_after_pop;
        logic [63:0] got, exp;
        logic [15:0] fb;
        nb = 1 + 8 + ((par != 0) ? 1 : 0) + stops;
        n  = nb * 4;
        fb = frame_bits(d, par);
        got = '0;
        exp = '0;
        for (int i = 0; i < n; i++) exp[i] = fb[i / 4];
        @(negedge clk);
        drive(idx, 1'b1, d);
        @(negedge clk);
        drive(idx, 1'b0, 8'h00);
        r_after_write = rdy[idx];
        r_after_pop = 1'b0;
        bcnt = int'(busy[idx]);
        lat = 0;
        while ((pin[idx] == 1'b1) && (lat < 20)) begin
            @(negedge clk);
            lat++;
            bcnt += int'(busy[idx]);
            if (lat == 1) r_after_pop = rdy[idx];
        end
        check({tag, "_latency"}, 64'(lat), 64'd2);
        check({tag, "_ready_full"}, 64'(r_after_write), 64'd0);
        check({tag, "_ready_popped"}, 64'(r_after_pop), 64'd1);
        got[0] = pin[idx];
        for (int i = 1; i < n; i++) begin
            @(negedge clk);
            got[i] = pin[idx];
            bcnt += int'(busy[idx]);
        end
        @(negedge clk);
        bcnt += int'(busy[idx]);
        check({tag, "_wave"}, got, exp);
        check({tag, "_idle_high"}, 64'(pin[idx]), 64'd1);
        check({tag, "_busy_cycles"}, 64'(bcnt), 64'(n + 1));
    endtask

    initial begin
        fork
            rx_mon(0, 4, 0, 1);
            rx_mon(1, 4, 2, 2);
            rx_mon(2, 4, 1, 1);
            rx_mon(3, 217, 0, 1);
        join_none
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        n_errors++;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        int base;
        int t;
        logic [7:0] q [6];
        for (int i = 0; i < 4; i++) begin
            rx_cnt[i] = 0;
            rx_rd[i] = 0;
            rx_ferr[i] = 0;
            drive(i, 1'b0, 8'h00);
        end
        repeat (3) @(negedge clk);
        check("rst_pin", 64'(pin), 64'hF);
        check("rst_ready", 64'(rdy), 64'hF);
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_overrun", 64'(ovr), 64'h0);
        n_rst = 1'b1;
        repeat (3) @(negedge clk);

        // Single 8N1 frame of 0x55.
        send_frame(0, 8'h55, 0, 1, "t1_55");
        expect_rx(0, 8'h55, "t1_rx");

        // Parity and two stop bits.
        send_frame(1, 8'h07, 2, 2, "t2_even");
        expect_rx(1, 8'h07, "t2_even_rx");
        send_frame(2, 8'h07, 1, 1, "t2_odd");
        expect_rx(2, 8'h07, "t2_odd_rx");

        // Random bytes through each 4 clk/bit instance.
        for (int k = 0; k < 3; k++) begin
            logic [7:0] r0, r1, r2;
            r0 = 8'($urandom_range(0, 255));
            r1 = 8'($urandom_range(0, 255));
            r2 = 8'($urandom_range(0, 255));
            send_frame(0, r0, 0, 1, "rnd_8n1");
            expect_rx(0, r0, "rnd_8n1_rx");
            send_frame(1, r1, 2, 2, "rnd_8e2");
            expect_rx(1, r1, "rnd_8e2_rx");
            send_frame(2, r2, 1, 1, "rnd_8o1");
            expect_rx(2, r2, "rnd_8o1_rx");
        end

        // Registered-enable producer: two writes back to back.
        base = rx_rd[0];
        @(negedge clk); drive(0, 1'b1, 8'h41);
        @(negedge clk); drive(0, 1'b1, 8'h42);
        @(negedge clk); drive(0, 1'b0, 8'h00);
        expect_rx(0, 8'h41, "t3_first");
        expect_rx(0, 8'h42, "t3_second");
        check("t3_no_gap", 64'(rx_start[0][base + 1] - rx_start[0][base]), 64'd40);
        check("t3_overrun", 64'(ovr[0]), 64'd0);

        // Four consecutive writes: fourth is dropped.
        base = rx_rd[0];
        for (int i = 0; i < 4; i++) q[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(0, 1'b1, q[i]);
        end
        @(negedge clk); drive(0, 1'b0, 8'h00);
        expect_rx(0, q[0], "t4_a");
        expect_rx(0, q[1], "t4_b");
        expect_rx(0, q[2], "t4_c");
        check("t4_gap_ab", 64'(rx_start[0][base + 1] - rx_start[0][base]), 64'd40);
        check("t4_gap_bc", 64'(rx_start[0][base + 2] - rx_start[0][base + 1]), 64'd40);
        repeat (100) @(negedge clk);
        check("t4_d_dropped", 64'(rx_cnt[0] - rx_rd[0]), 64'd0);
        check("t4_overrun_sticky", 64'(ovr[0]), 64'd1);

        // Reset in the middle of the data bits of 0xA3.
        @(negedge clk); drive(0, 1'b1, 8'hA3);
        @(negedge clk); drive(0, 1'b0, 8'h00);
        t = 0;
        while ((pin[0] == 1'b1) && (t < 20)) begin
            @(negedge clk);
            t++;
        end
        check("t5_start_seen", 64'(pin[0]), 64'd0);
        repeat (4 + 9) @(negedge clk);
        check("t5_mid_frame_busy", 64'(busy[0]), 64'd1);
        n_rst = 1'b0;
        #1;
        check("t5_rst_pin", 64'(pin[0]), 64'd1);
        check("t5_rst_ready", 64'(rdy[0]), 64'd1);
        check("t5_rst_busy", 64'(busy[0]), 64'd0);
        check("t5_rst_overrun", 64'(ovr[0]), 64'd0);
        @(negedge clk);
        @(negedge clk);
        n_rst = 1'b1;
        repeat (60) @(negedge clk);
        rx_cnt[0] = 0;
        rx_rd[0] = 0;
        rx_ferr[0] = 0;
        send_frame(0, 8'h3C, 0, 1, "t5_3c");
        expect_rx(0, 8'h3C, "t5_rx");

        // 217 clk/bit instance, producer writes whenever ready is seen.
        for (int i = 0; i < 6; i++) q[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 6; i++) begin
            t = 0;
            while ((rdy[3] == 1'b0) && (t < 5000)) begin
                @(negedge clk);
                t++;
            end
            check("t6_ready_wait", 64'(rdy[3]), 64'd1);
            @(negedge clk); drive(3, 1'b1, q[i]);
            @(negedge clk); drive(3, 1'b0, 8'h00);
        end
        for (int i = 0; i < 6; i++) expect_rx(3, q[i], "t6_rx");
        check("t6_span", 64'(rx_start[3][5] - rx_start[3][0]), 64'd10850);
        check("t6_overrun", 64'(ovr[3]), 64'd0);

        for (int i = 0; i < 4; i++) check("frame_errors", 64'(rx_ferr[i]), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
